if_stage: RTL and testbench

Instruction-fetch stage of the pipelined CPU: holds the PC, issues instruction-memory requests over a req/ack handshake, and presents `{instruction, PC+4, valid}` to the IF/ID pipeline register every cycle. It sits directly upstream of the IF/ID `reg_pipe` instance. Its outputs are combinational to that register, which captures whenever `stall` is low. It absorbs variable memory latency, downstream stalls and branch/jump redirects from ID, inserting NOP bubbles where needed.

---
 rtl/if_stage.sv | 154 +++++++++++++++
 tb/tb_if_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem req/ack handshake and
// presents {instruction, PC+4, valid} combinationally to the IF/ID register.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [25:0] jmp_index,
    input  logic [31:0] id_pc4,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc4
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   w_pc_nxt;
    logic [XLEN-1:0]   r_drain_addr;
    logic [XLEN-1:0]   w_drain_addr_nxt;
    logic [XLEN-1:0]   r_hold_instr;
    logic [XLEN-1:0]   w_hold_instr_nxt;
    logic [XLEN-1:0]   r_hold_pc4;
    logic [XLEN-1:0]   w_hold_pc4_nxt;

    logic              w_redir;
    logic [XLEN-1:0]   w_target;
    logic [XLEN-1:0]   w_pc_plus4;
    logic              w_req;
    logic [XLEN-1:0]   w_addr;
    logic              w_valid;
    logic [XLEN-1:0]   w_instr;
    logic [XLEN-1:0]   w_pc4;
    logic              w_unused;

    // Redirects are only honoured when IF/ID is actually advancing; branch wins over jump.
    assign w_redir    = (br_taken | jmp) & ~stall;
    assign w_target   = br_taken ? {br_target[31:2], 2'b00}
                                 : {id_pc4[31:28], jmp_index, 2'b00};
    assign w_pc_plus4 = r_pc + XLEN'(4);
    assign w_unused   = ^{id_pc4[27:0], br_target[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_drain_addr <= '0;
            r_hold_instr <= '0;
            r_hold_pc4   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_drain_addr <= w_drain_addr_nxt;
            r_hold_instr <= w_hold_instr_nxt;
            r_hold_pc4   <= w_hold_pc4_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_drain_addr_nxt = r_drain_addr;
        w_hold_instr_nxt = r_hold_instr;
        w_hold_pc4_nxt   = r_hold_pc4;
        w_req            = 1'b0;
        w_addr           = r_pc;
        w_valid          = 1'b0;
        w_instr          = NOP;
        w_pc4            = '0;

        case (r_state)
            S_FETCH: begin
                w_req = 1'b1;
                if (imem_ack) begin
                    if (stall) begin
                        w_hold_instr_nxt = imem_rdata;
                        w_hold_pc4_nxt   = w_pc_plus4;
                        w_pc_nxt         = w_pc_plus4;
                        w_state_nxt      = S_HOLD;
                    end else if (w_redir) begin
                        w_pc_nxt = w_target;
                    end else begin
                        w_valid  = 1'b1;
                        w_instr  = imem_rdata;
                        w_pc4    = w_pc_plus4;
                        w_pc_nxt = w_pc_plus4;
                    end
                end else if (w_redir) begin
                    // Outstanding request must still complete; remember where it went.
                    w_drain_addr_nxt = r_pc;
                    w_pc_nxt         = w_target;
                    w_state_nxt      = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    w_valid     = 1'b1;
                    w_instr     = r_hold_instr;
                    w_pc4       = r_hold_pc4;
                    w_state_nxt = S_FETCH;
                    if (w_redir) begin
                        w_pc_nxt = w_target;
                    end
                end
            end
            S_DRAIN: begin
                w_req  = 1'b1;
                w_addr = r_drain_addr;
                if (w_redir) begin
                    w_pc_nxt = w_target;
                end
                if (imem_ack) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase

        // Reset drops the request and bubbles the outputs without waiting for a clock.
        if (!rst) begin
            w_req   = 1'b0;
            w_addr  = r_pc;
            w_valid = 1'b0;
            w_instr = NOP;
            w_pc4   = '0;
        end
    end

    assign imem_req  = w_req;
    assign imem_addr = w_addr;
    assign if_valid  = w_valid;
    assign if_instr  = w_instr;
    assign if_pc4    = w_pc4;

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage: streaming fetch, memory latency,
// stall hold, branch/jump redirects, drain, reset abort and PC wrap.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp;
    logic [25:0] jmp_index;
    logic [31:0] id_pc4;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc4;

    int unsigned n_checks;
    int unsigned n_fail;

    localparam logic [31:0] XORK = 32'hA5A5_0000;

    if_stage dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .br_taken  (br_taken),
        .br_target (br_target),
        .jmp       (jmp),
        .jmp_index (jmp_index),
        .id_pc4    (id_pc4),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .if_valid  (if_valid),
        .if_instr  (if_instr),
        .if_pc4    (if_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Check the full output bundle at the negedge of the current cycle.
    task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                           input logic vld, input logic [31:0] ins, input logic [31:0] pc4);
        chk({tag, ".req"},   32'(imem_req), 32'(req));
        chk({tag, ".addr"},  imem_addr, addr);
        chk({tag, ".valid"}, 32'(if_valid), 32'(vld));
        chk({tag, ".instr"}, if_instr, ins);
        chk({tag, ".pc4"},   if_pc4, pc4);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        stall = 0; br_taken = 0; br_target = 0; jmp = 0; jmp_index = 0; id_pc4 = 0;
        imem_ack = 0; imem_rdata = 0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        idle_in();

        // Reset state before any clock edge
        #3;
        chk_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        next_cycle();
        rst = 1'b1;

        // Zero-wait streaming: 0,4,8,C
        for (int i = 0; i < 4; i++) begin
            imem_ack = 1; imem_rdata = 32'(i * 4) ^ XORK;
            @(negedge clk);
            chk_out("stream", 1'b1, 32'(i * 4), 1'b1, 32'(i * 4) ^ XORK, 32'(i * 4 + 4));
            next_cycle();
        end

        // Two-cycle latency at 0x10
        for (int i = 0; i < 3; i++) begin
            imem_ack = (i == 2); imem_rdata = 32'h10 ^ XORK;
            @(negedge clk);
            if (i < 2) chk_out("lat_wait", 1'b1, 32'h10, 1'b0, 32'h0, 32'h0);
            else       chk_out("lat_ack", 1'b1, 32'h10, 1'b1, 32'h10 ^ XORK, 32'h14);
            next_cycle();
        end

        // Stall in ack cycle of 0x14 for 3 cycles
        imem_ack = 1; imem_rdata = 32'h14 ^ XORK; stall = 1;
        @(negedge clk);
        chk_out("stall_ack", 1'b1, 32'h14, 1'b0, 32'h0, 32'h0);
        next_cycle();
        imem_ack = 0; imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("hold.req", 32'(imem_req), 32'h0);
            chk("hold.valid", 32'(if_valid), 32'h0);
            chk("hold.instr", if_instr, 32'h0);
            next_cycle();
        end
        stall = 0;
        @(negedge clk);
        chk("hold_rel.req", 32'(imem_req), 32'h0);
        chk("hold_rel.valid", 32'(if_valid), 32'h1);
        chk("hold_rel.instr", if_instr, 32'h14 ^ XORK);
        chk("hold_rel.pc4", if_pc4, 32'h18);
        next_cycle();

        // Branch while waiting on 0x18 -> drain, then fetch 0x100
        br_taken = 1; br_target = 32'h100;
        @(negedge clk);
        chk_out("br_wait", 1'b1, 32'h18, 1'b0, 32'h0, 32'h0);
        next_cycle();
        br_taken = 0; br_target = 0;
        @(negedge clk);
        chk_out("drain_wait", 1'b1, 32'h18, 1'b0, 32'h0, 32'h0);
        next_cycle();
        imem_ack = 1; imem_rdata = 32'h18 ^ XORK;
        @(negedge clk);
        chk_out("drain_ack", 1'b1, 32'h18, 1'b0, 32'h0, 32'h0);
        next_cycle();

        // Jump at 0x100 with ack: wrong-path data dropped
        jmp = 1; id_pc4 = 32'h4000_0010; jmp_index = 26'h40; imem_rdata = 32'h100 ^ XORK;
        @(negedge clk);
        chk_out("jmp", 1'b1, 32'h100, 1'b0, 32'h0, 32'h0);
        next_cycle();

        // Branch beats jump; low target bits forced to 0
        br_taken = 1; br_target = 32'h203; imem_rdata = 32'h4000_0100 ^ XORK;
        @(negedge clk);
        chk_out("jmp_tgt", 1'b1, 32'h4000_0100, 1'b0, 32'h0, 32'h0);
        next_cycle();

        // Redirect under stall is ignored
        stall = 1; imem_ack = 0;
        @(negedge clk);
        chk_out("br_prio", 1'b1, 32'h200, 1'b0, 32'h0, 32'h0);
        next_cycle();
        stall = 0; br_taken = 0; jmp = 0; imem_ack = 1; imem_rdata = 32'h200 ^ XORK;
        @(negedge clk);
        chk_out("stall_redir_ign", 1'b1, 32'h200, 1'b1, 32'h200 ^ XORK, 32'h204);
        next_cycle();

        // Enter DRAIN from 0x204, then reset mid-drain
        imem_ack = 0; br_taken = 1; br_target = 32'h300;
        @(negedge clk);
        next_cycle();
        br_taken = 0; br_target = 0;
        @(negedge clk);
        chk_out("drain2", 1'b1, 32'h204, 1'b0, 32'h0, 32'h0);
        #2;
        rst = 1'b0;
        #1;
        chk_out("rst_drain", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        next_cycle();
        rst = 1'b1;

        // First fetch after reset at RESET_PC, branch to the top word
        imem_ack = 1; imem_rdata = XORK; br_taken = 1; br_target = 32'hFFFF_FFFC;
        @(negedge clk);
        chk_out("post_rst", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        next_cycle();
        br_taken = 0; br_target = 0; imem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk_out("wrap", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h1234_5678, 32'h0);
        next_cycle();
        imem_ack = 0;
        @(negedge clk);
        chk_out("wrap_next", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
